// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller and the datapath that drives it.
// Holds the controller state encoding and the default bus timeout.
package data_mem_ctrl_pkg;

   localparam int unsigned TIMEOUT_DEFAULT = 16;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/data_mem_ctrl_bus_timer.sv
// Saturating counter of BUSY cycles without a bus acknowledge.
// o_expired is high on the last permitted cycle, which is when the count equals TIMEOUT-1.
module data_mem_ctrl_bus_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] r_cnt;

   // Holds at TIMEOUT so a stuck enable can never wrap back to zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != TW'(TIMEOUT))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: turns datapath load/store requests into single registered bus
// transactions, stalling the datapath until the bus completes, times out or rejects a misalignment.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_cpu_rst_n,
   input  logic        i_cpu_en,
   input  logic        i_mem_ren,
   input  logic        i_mem_wen,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_dout,
   output logic [31:0] o_mem_din,
   output logic        o_mem_stall,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rdata,
   output logic        o_err_misalign,
   output logic        o_err_timeout
);

   state_e      r_state;
   logic [31:0] r_rdata;
   logic        w_start;
   logic        w_misalign;
   logic        w_timer_en;
   logic        w_expired;

   assign w_start    = (r_state == StIdle) && i_cpu_en && (i_mem_ren || i_mem_wen);
   assign w_misalign = (i_mem_addr[1:0] != 2'b00);
   assign w_timer_en = (r_state == StBusy) && !i_bus_ack;

   assign o_mem_stall = w_start || (r_state == StBusy);
   assign o_mem_din   = r_rdata;

   data_mem_ctrl_bus_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_bus_timer (
      .i_clk     (i_clk),
      .i_rst_n   (i_cpu_rst_n),
      .i_clr     (w_start),
      .i_en      (w_timer_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge i_clk or negedge i_cpu_rst_n) begin
      if (!i_cpu_rst_n) begin
         r_state        <= StIdle;
         r_rdata        <= '0;
         o_bus_req      <= 1'b0;
         o_bus_we       <= 1'b0;
         o_bus_addr     <= '0;
         o_bus_wdata    <= '0;
         o_err_misalign <= 1'b0;
         o_err_timeout  <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_start) begin
                  if (w_misalign) begin
                     o_err_misalign <= 1'b1;
                     r_rdata        <= '0;
                     r_state        <= StDone;
                  end else begin
                     // A simultaneous load and store request resolves to a store.
                     o_bus_req   <= 1'b1;
                     o_bus_we    <= i_mem_wen;
                     o_bus_addr  <= {i_mem_addr[31:2], 2'b00};
                     o_bus_wdata <= i_mem_dout;
                     r_state     <= StBusy;
                  end
               end
            end
            StBusy: begin
               // Ack is tested first so it wins over a coincident timeout.
               if (i_bus_ack) begin
                  if (!o_bus_we) begin
                     r_rdata <= i_bus_rdata;
                  end
                  o_bus_req <= 1'b0;
                  r_state   <= StDone;
               end else if (w_expired) begin
                  o_bus_req     <= 1'b0;
                  o_err_timeout <= 1'b1;
                  r_rdata       <= '0;
                  r_state       <= StDone;
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule
